mem_arbiter: RTL and testbench

Two-port round-robin arbiter that shares the single-port 255x32 RAM peripheral between the CPU (port 0) and a second bus master (port 1, DMA). It accepts one request per transaction through a req/gnt handshake and drives the RAM's addr/data_in/write_enable/read_enable. It captures the RAM's registered read data and returns it to the owning port with a one-cycle valid pulse. It sits between the bus masters and `memory_peripheral`; nothing else drives the RAM.

---
 rtl/mem_arb_pkg.sv | 14 +
 rtl/mem_arbiter_rr_pick2.sv | 17 +
 rtl/mem_arbiter.sv | 93 +++++++++
 tb/tb_mem_arbiter.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port RAM arbiter.
package mem_arb_pkg;
  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 32;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DMA = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DATA  = 2'd2
  } arb_state_t;
endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// Combinational two-way round-robin winner select; last_grant lives in the parent.
module rr_pick2
  import mem_arb_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic any_req,
  output logic winner
);
  always_comb begin
    any_req = req0 | req1;
    if (req0 && req1) winner = ~last_grant;
    else if (req1)    winner = PORT_DMA;
    else              winner = PORT_CPU;
  end
endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between CPU (port 0) and DMA (port 1).
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);
  arb_state_t        state, state_nxt;
  logic              last_grant, owner, cmd_we;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              any_req, winner, accept;

  rr_pick2 u_pick (
    .req0       (req0),
    .req1       (req1),
    .last_grant (last_grant),
    .any_req    (any_req),
    .winner     (winner)
  );

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE:    if (any_req) begin accept = 1'b1; state_nxt = ISSUE; end
      ISSUE:   state_nxt = cmd_we ? IDLE : DATA;
      DATA:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    // Command registers drive the RAM bus directly, so it holds outside ISSUE.
    gnt0      = (state == ISSUE) && (owner == PORT_CPU);
    gnt1      = (state == ISSUE) && (owner == PORT_DMA);
    mem_we    = (state == ISSUE) &&  cmd_we;
    mem_re    = (state == ISSUE) && !cmd_we;
    mem_addr  = cmd_addr;
    mem_wdata = cmd_wdata;
    busy      = (state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= PORT_DMA;
      owner      <= PORT_CPU;
      cmd_we     <= 1'b0;
      cmd_addr   <= '0;
      cmd_wdata  <= '0;
      rvalid0    <= 1'b0;
      rvalid1    <= 1'b0;
      rdata0     <= '0;
      rdata1     <= '0;
    end else begin
      state   <= state_nxt;
      rvalid0 <= (state == DATA) && (owner == PORT_CPU);
      rvalid1 <= (state == DATA) && (owner == PORT_DMA);
      if (accept) begin
        owner      <= winner;
        last_grant <= winner;
        cmd_we     <= winner ? we1    : we0;
        cmd_addr   <= winner ? addr1  : addr0;
        cmd_wdata  <= winner ? wdata1 : wdata0;
      end
      if (state == DATA) begin
        if (owner == PORT_DMA) rdata1 <= mem_rdata;
        else                   rdata0 <= mem_rdata;
      end
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter against a transaction-schedule reference model.
module tb_mem_arbiter;
  localparam int AW = 16, DW = 32, NCYC = 4096;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } txn_t;

  logic          clk = 1'b0, reset;
  logic          req0, req1, we0, we1, gnt0, gnt1, rvalid0, rvalid1;
  logic [AW-1:0] addr0, addr1, mem_addr;
  logic [DW-1:0] wdata0, wdata1, rdata0, rdata1, mem_wdata, mem_rdata;
  logic          mem_we, mem_re, busy;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  // 255-word RAM with word index clamped to the last location.
  function automatic int widx(input logic [AW-1:0] a);
    int i;
    i = int'(a >> 2);
    return (i > 254) ? 254 : i;
  endfunction

  logic [DW-1:0] ram [0:254];
  always @(posedge clk) begin
    if (mem_we) ram[widx(mem_addr)] <= mem_wdata;
    if (mem_re) mem_rdata <= ram[widx(mem_addr)];
  end

  // Reference model: schedule of expected events indexed by cycle number.
  int            cyc, checks, failures;
  bit            e_busy [NCYC];
  bit            e_iss  [NCYC];
  bit            e_iss_port [NCYC];
  txn_t          e_iss_t [NCYC];
  bit            e_rv   [NCYC];
  bit            e_rv_port [NCYC];
  logic [DW-1:0] e_rv_data [NCYC];
  logic [DW-1:0] m_mem [int];
  logic [DW-1:0] m_rdata [2];
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  bit            m_last, rst_pend, rst_cmd, rnd_mode;

  txn_t q0[$], q1[$];
  txn_t cur [2];
  bit   has_req [2];
  bit   rel [2];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic txn_t rand_txn();
    txn_t t;
    t.we    = 1'($urandom_range(0, 1));
    t.addr  = AW'($urandom_range(0, 1100));
    t.wdata = $urandom;
    return t;
  endfunction

  task automatic port_upd(input int p, input logic g);
    if (g) rel[p] = 1'b1;
    else if (rel[p]) begin rel[p] = 1'b0; has_req[p] = 1'b0; end
    if (!has_req[p] && !rel[p]) begin
      if (p == 0) begin
        if (rnd_mode && q0.size() == 0 && $urandom_range(0, 2) == 0) q0.push_back(rand_txn());
        if (q0.size() > 0) begin cur[0] = q0.pop_front(); has_req[0] = 1'b1; end
      end else begin
        if (rnd_mode && q1.size() == 0 && $urandom_range(0, 2) == 0) q1.push_back(rand_txn());
        if (q1.size() > 0) begin cur[1] = q1.pop_front(); has_req[1] = 1'b1; end
      end
    end
  endtask

  task automatic step();
    txn_t t;
    bit   w;
    int   i;
    @(posedge clk); #1;
    cyc++;
    if (cyc >= NCYC - 4) begin
      $display("FAIL cycle_budget cyc=%0d limit=%0d", cyc, NCYC - 4);
      $fatal(1);
    end
    if (rst_pend) begin
      m_rdata = '{default: '0}; m_addr = '0; m_wdata = '0; rst_pend = 1'b0;
    end
    if (e_iss[cyc]) begin
      t = e_iss_t[cyc]; m_addr = t.addr; m_wdata = t.wdata; i = widx(t.addr);
      if (t.we) m_mem[i] = t.wdata;
      else begin
        e_rv[cyc+2] = 1'b1; e_rv_port[cyc+2] = e_iss_port[cyc];
        e_rv_data[cyc+2] = m_mem.exists(i) ? m_mem[i] : '0;
      end
    end
    if (e_rv[cyc]) m_rdata[e_rv_port[cyc]] = e_rv_data[cyc];

    chk("gnt", {gnt1, gnt0}, !e_iss[cyc] ? 2'b00 : (e_iss_port[cyc] ? 2'b10 : 2'b01));
    chk("mem_we_re", {mem_we, mem_re}, !e_iss[cyc] ? 2'b00 : (e_iss_t[cyc].we ? 2'b10 : 2'b01));
    chk("mem_addr", mem_addr, m_addr);
    chk("mem_wdata", mem_wdata, m_wdata);
    chk("rvalid", {rvalid1, rvalid0}, !e_rv[cyc] ? 2'b00 : (e_rv_port[cyc] ? 2'b10 : 2'b01));
    chk("rdata0", rdata0, m_rdata[0]);
    chk("rdata1", rdata1, m_rdata[1]);
    chk("busy", busy, e_busy[cyc]);

    reset = rst_cmd;
    if (rst_cmd) begin
      q0.delete(); q1.delete();
      has_req = '{default: 1'b0}; rel = '{default: 1'b0};
      m_last = 1'b1; rst_pend = 1'b1;
      for (int c = cyc + 1; c < NCYC; c++) begin
        e_busy[c] = 1'b0; e_iss[c] = 1'b0; e_rv[c] = 1'b0;
      end
    end else begin
      port_upd(0, gnt0);
      port_upd(1, gnt1);
    end
    req0 = has_req[0]; {we0, addr0, wdata0} = cur[0];
    req1 = has_req[1]; {we1, addr1, wdata1} = cur[1];

    // The arbiter evaluates requests only in an IDLE cycle, outside reset.
    if (!rst_cmd && !e_busy[cyc] && (has_req[0] || has_req[1])) begin
      w = (has_req[0] && has_req[1]) ? ~m_last : has_req[1];
      m_last = w;
      e_iss[cyc+1] = 1'b1; e_iss_port[cyc+1] = w; e_iss_t[cyc+1] = cur[w];
      e_busy[cyc+1] = 1'b1;
      if (!cur[w].we) e_busy[cyc+2] = 1'b1;
    end
  endtask

  function automatic bit quiet();
    return q0.size() == 0 && q1.size() == 0 && !has_req[0] && !has_req[1] &&
           !e_busy[cyc+1] && !e_rv[cyc+1] && !e_rv[cyc+2];
  endfunction

  task automatic drain(input int bound);
    int n = 0;
    bit done;
    do begin step(); n++; end while (!quiet() && n < bound);
    done = quiet();
    chk("drain", done, 1'b1);
  endtask

  initial begin
    logic [DW-1:0] oor_val;
    txn_t t;
    for (int i = 0; i < 255; i++) ram[i] = '0;
    mem_rdata = '0;
    reset = 1'b1; req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    cyc = 0; checks = 0; failures = 0;
    m_rdata = '{default: '0}; m_addr = '0; m_wdata = '0; m_last = 1'b1;
    rst_pend = 0; rnd_mode = 0; rst_cmd = 1'b1;
    cur = '{default: '0}; has_req = '{default: 1'b0}; rel = '{default: 1'b0};

    repeat (3) step();
    rst_cmd = 1'b0;

    q0.push_back('{1'b1, 16'h0008, 32'hDEADBEEF});
    drain(40);
    chk("ram_w2", ram[2], 32'hDEADBEEF);

    q1.push_back('{1'b0, 16'h0008, 32'h0});
    drain(40);
    chk("readback1", rdata1, 32'hDEADBEEF);
    chk("rdata0_kept", rdata0, 32'h0);

    // Reset held three cycles while a read sits in its DATA cycle.
    q1.push_back('{1'b0, 16'h0008, 32'h0});
    step(); step();
    rst_cmd = 1'b1;
    repeat (3) step();
    rst_cmd = 1'b0;
    step();
    chk("rst_busy", busy, 1'b0);
    chk("rst_rdata1", rdata1, 32'h0);
    drain(40);

    for (int i = 0; i < 4; i++) begin
      q0.push_back('{1'b0, 16'h0000, 32'h0});
      q1.push_back('{1'b0, 16'h0004, 32'h0});
    end
    step(); step();
    chk("tie_first", {gnt1, gnt0}, 2'b01);
    drain(80);

    for (int i = 0; i < 6; i++) begin
      t.we = 1'b1; t.addr = AW'((10 + i) * 4); t.wdata = $urandom;
      q0.push_back(t);
    end
    for (int i = 0; i < 3; i++) q1.push_back('{1'b0, AW'((10 + i) * 4), 32'h0});
    drain(200);

    oor_val = $urandom;
    q0.push_back('{1'b1, 16'h03F8, oor_val});
    q0.push_back('{1'b0, 16'h03FC, 32'h0});
    drain(40);
    chk("ram_w254", ram[254], oor_val);
    chk("oor_rdata0", rdata0, oor_val);

    rnd_mode = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      rst_cmd = (i == 700 || i == 701);
      step();
    end
    rst_cmd = 1'b0;
    rnd_mode = 1'b0;
    drain(60);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
